arith_rr_arbiter: RTL and testbench
===================================

Name: arith_rr_arbiter

Overview:
Shares the single 16-bit arithmetic unit (add/sub/mul/and, 2-bit op select, combinational result) between NUM_REQ requesters.
- Arbitration is round-robin.
- The block latches the winner's operands and opcode, drives the unit's inputs from registers, and captures the result.
- The result is returned through a valid/ready response channel tagged with the requester index.
- Sits between the requesting datapath blocks and the one shared arithmetic unit instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of requester index; must equal ceil(log2(NUM_REQ))

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester request; held until that requester's grant bit is seen
req_op  input  2*NUM_REQ  per-requester op select, slice i = [2i+1:2i]; 00 add, 01 sub, 10 mul, 11 and
req_a  input  16*NUM_REQ  per-requester operand 1, slice i = [16i+15:16i]
req_b  input  16*NUM_REQ  per-requester operand 2, same slicing
grant  output  NUM_REQ  one-hot, one-cycle accept pulse to the selected requester
au_data_1  output  16  registered operand 1 to arithmetic unit
au_data_2  output  16  registered operand 2 to arithmetic unit
au_op_sel  output  2  registered op select to arithmetic unit
au_result  input  16  combinational result from arithmetic unit
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  ID_W  index of requester owning rsp_data
rsp_data  output  16  captured result
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous; wins over all other events, including mid-operation):
  - state=IDLE.
  - grant=0, rsp_valid=0, rsp_id=0, rsp_data=0, au_data_1=0, au_data_2=0, au_op_sel=00, busy=0.
  - Priority pointer last=NUM_REQ-1, so index 0 has highest priority first.
  - An in-flight operation or pending response is discarded; no grant or response is issued for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If req != 0, select the first set bit searching (last+1), (last+2), ... modulo NUM_REQ.
  - At the clock edge: latch that requester's req_a/req_b/req_op into au_data_1/au_data_2/au_op_sel; rsp_id<=index; last<=index; grant<=onehot(index); state<=EXEC.
  - If req == 0: stay in IDLE; all registers hold.
- EXEC (exactly 1 cycle):
  - grant is high for this cycle only.
  - au_* inputs are stable; at the edge rsp_data<=au_result, rsp_valid<=1, grant<=0, state<=RESP.
- RESP:
  - rsp_valid, rsp_id and rsp_data held stable until the handshake.
  - On rsp_valid && rsp_ready at the edge: rsp_valid<=0, state<=IDLE.
  - Requests arriving during EXEC/RESP wait; no grant is issued until IDLE.
- au_* registers hold their last values outside IDLE transitions; they do not return to 0.
- Latency: request seen in IDLE cycle T gives grant in T+1 and rsp_valid in T+2. With rsp_ready tied high, one operation completes every 3 cycles.
- Arithmetic: result width is 16 bits, computed by the arithmetic unit. Mul keeps the low 16 bits; sub wraps modulo 2^16. The block passes the result through unmodified.
- Requester contract: req is deasserted in the cycle after grant is seen. A req held past that cycle is treated as a new request in the next IDLE.
- Operands changing after latch (during EXEC/RESP) have no effect.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 operations.
- Simultaneous requests: exactly one grant per operation. grant is never multi-hot, and never asserted outside EXEC.

Test Plan:
- Reset then single request: req=0001, op=00, a=0x1234, b=0x0101 -> grant=0001 at T+1, rsp_valid at T+2 with rsp_id=0, rsp_data=0x1335.
- Op coverage and wrap:
  - sub 5-7 -> 0xFFFE.
  - mul 300*300 -> 0x5F90.
  - and 0xF0F0&0x0FF0 -> 0x00F0.
- All four requesters continuously requesting, rsp_ready=1:
  - grant order is 0,1,2,3,0 with one grant every 3 cycles.
  - Then drop req0 only -> order 1,2,3,1.
- Backpressure: rsp_ready=0 for 5 cycles with req=0110 pending -> rsp_valid/rsp_id/rsp_data stable, no grant. Then rsp_ready=1 -> IDLE, next grant=0100 if last=1.
- Reset asserted in EXEC and again in RESP -> next cycle all outputs at reset values, no response emitted; a following req=1000 gets grant=1000 (pointer restarted at 0).
- Operand change after grant: modify req_a of the granted requester during EXEC -> rsp_data reflects the originally latched operands.

Source files
------------

// File: rtl/arith_rr_arbiter.sv
// Round-robin front end for one shared 16-bit arithmetic unit.
// Picks one requester per operation, registers its operands and opcode into
// the unit, captures the unit's result and returns it on a valid/ready
// response channel tagged with the requester index.
module arith_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [2*NUM_REQ-1:0]  req_op,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]    grant,
  output logic [15:0]           au_data_1,
  output logic [15:0]           au_data_2,
  output logic [1:0]            au_op_sel,
  input  logic [15:0]           au_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic [15:0]           rsp_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] last;
  logic [ID_W-1:0] sel_id;
  logic            sel_found;
  logic [15:0]     slot_a  [NUM_REQ];
  logic [15:0]     slot_b  [NUM_REQ];
  logic [1:0]      slot_op [NUM_REQ];

  // Split the flat per-requester buses into indexable slots.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      slot_a[i]  = req_a[16*i +: 16];
      slot_b[i]  = req_b[16*i +: 16];
      slot_op[i] = req_op[2*i +: 2];
    end
  end

  // Round-robin search: first set request starting just after the last winner.
  always_comb begin
    int cand;
    logic [ID_W-1:0] cand_id;
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    sel_found = 1'b0;
    sel_id    = '0;
    cand      = 0;
    cand_id   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand    = (int'(last) + k) % NUM_REQ;
      cand_id = ID_W'(cand);
      if (!sel_found && req[cand_id]) begin
        sel_found = 1'b1;
        sel_id    = cand_id;
      end
    end
  end

  // State register; synchronous reset wins over everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: EXEC is always exactly one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (sel_found) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: busy covers the whole operation including the response.
  always_comb begin
    busy = (state != IDLE);
  end

  // Datapath registers: operand latch, grant pulse, result capture, response.
  always_ff @(posedge clk) begin
    if (reset) begin
      last      <= ID_W'(NUM_REQ - 1);
      grant     <= '0;
      au_data_1 <= '0;
      au_data_2 <= '0;
      au_op_sel <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            au_data_1 <= slot_a[sel_id];
            au_data_2 <= slot_b[sel_id];
            au_op_sel <= slot_op[sel_id];
            rsp_id    <= sel_id;
            last      <= sel_id;
            grant     <= NUM_REQ'(1) << sel_id;
          end
        end
        EXEC: begin
          rsp_data  <= au_result;
          rsp_valid <= 1'b1;
          grant     <= '0;
        end
        RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_arith_rr_arbiter.sv
// Directed bench for arith_rr_arbiter with a behavioural arithmetic unit.
module tb_arith_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NUM_REQ-1:0]    req;
  logic [2*NUM_REQ-1:0]  req_op;
  logic [16*NUM_REQ-1:0] req_a;
  logic [16*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]    grant;
  logic [15:0]           au_data_1;
  logic [15:0]           au_data_2;
  logic [1:0]            au_op_sel;
  logic [15:0]           au_result;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [15:0]           rsp_data;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  arith_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .grant     (grant),
    .au_data_1 (au_data_1),
    .au_data_2 (au_data_2),
    .au_op_sel (au_op_sel),
    .au_result (au_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Shared arithmetic unit model.
  always_comb begin
    case (au_op_sel)
      2'b00:   au_result = au_data_1 + au_data_2;
      2'b01:   au_result = au_data_1 - au_data_2;
      2'b10:   au_result = 16'(au_data_1 * au_data_2);
      default: au_result = au_data_1 & au_data_2;
    endcase
  end

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  exp_grant;
    logic [1:0]  exp_id;
    logic [15:0] exp_data;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [1:0] op, input logic [15:0] a,
                          input logic [15:0] b);
    req_op[2*i +: 2]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"},     grant,     0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_id"},    rsp_id,    0);
    check({tag, "_rsp_data"},  rsp_data,  0);
    check({tag, "_au_data_1"}, au_data_1, 0);
    check({tag, "_au_data_2"}, au_data_2, 0);
    check({tag, "_au_op_sel"}, au_op_sel, 0);
    check({tag, "_busy"},      busy,      0);
  endtask

  int order [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 1};
  logic [15:0] held_data;

  initial begin
    vecs[0] = '{4'b0001, 2'b00, 16'h1234, 16'h0101, 4'b0001, 2'd0, 16'h1335};
    vecs[1] = '{4'b0010, 2'b01, 16'h0005, 16'h0007, 4'b0010, 2'd1, 16'hFFFE};
    vecs[2] = '{4'b0100, 2'b10, 16'd300,  16'd300,  4'b0100, 2'd2, 16'h5F90};
    vecs[3] = '{4'b1000, 2'b11, 16'hF0F0, 16'h0FF0, 4'b1000, 2'd3, 16'h00F0};
    vecs[4] = '{4'b1001, 2'b00, 16'hFFFF, 16'h0002, 4'b0001, 2'd0, 16'h0001};
    vecs[5] = '{4'b1001, 2'b10, 16'h0100, 16'h0100, 4'b1000, 2'd3, 16'h0000};
    vecs[6] = '{4'b0110, 2'b01, 16'h8000, 16'h0001, 4'b0010, 2'd1, 16'h7FFF};

    reset     = 1'b1;
    req       = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    reset = 1'b0;

    // Table: one full transaction per vector; decoy operands in losing slots.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < NUM_REQ; i++) set_slot(i, 2'b11, 16'hDEAD, 16'hBEEF);
      set_slot(int'(vecs[v].exp_id), vecs[v].op, vecs[v].a, vecs[v].b);
      req = vecs[v].req;
      tick();
      check($sformatf("v%0d_grant", v), grant, vecs[v].exp_grant);
      check($sformatf("v%0d_au_a", v), au_data_1, vecs[v].a);
      check($sformatf("v%0d_busy", v), busy, 1);
      req = '0;
      tick();
      check($sformatf("v%0d_valid", v), rsp_valid, 1);
      check($sformatf("v%0d_id", v), rsp_id, vecs[v].exp_id);
      check($sformatf("v%0d_data", v), rsp_data, vecs[v].exp_data);
      check($sformatf("v%0d_grant_off", v), grant, 0);
      tick();
      check($sformatf("v%0d_done", v), rsp_valid, 0);
      check($sformatf("v%0d_idle", v), busy, 0);
      check($sformatf("v%0d_au_hold", v), au_data_1, vecs[v].a);
    end

    // All requesters continuously requesting, then requester 0 drops out.
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 2'b00, 16'(i * 256), 16'h0001);
    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      tick();
      check($sformatf("rr%0d_grant", k), grant, 4'b0001 << order[k]);
      if (k == 4) req = 4'b1110;
      if (k == 8) req = 4'b0000;
      tick();
      check($sformatf("rr%0d_gap1", k), grant, 0);
      check($sformatf("rr%0d_id", k), rsp_id, order[k]);
      check($sformatf("rr%0d_data", k), rsp_data, 16'(order[k] * 256 + 1));
      tick();
      check($sformatf("rr%0d_gap2", k), grant, 0);
    end
    tick();
    check("rr_quiet", busy, 0);

    // Backpressure with pending requests, then resume from last=1.
    do_reset();
    set_slot(1, 2'b00, 16'h0040, 16'h0002);
    set_slot(2, 2'b01, 16'h0009, 16'h0004);
    req = 4'b0010;
    tick();
    check("bp_grant1", grant, 4'b0010);
    req       = 4'b0000;
    rsp_ready = 1'b0;
    tick();
    check("bp_valid", rsp_valid, 1);
    held_data = 16'h0042;
    check("bp_data0", rsp_data, held_data);
    req = 4'b0110;
    for (int c = 0; c < 5; c++) begin
      tick();
      check($sformatf("bp%0d_valid", c), rsp_valid, 1);
      check($sformatf("bp%0d_id", c), rsp_id, 1);
      check($sformatf("bp%0d_data", c), rsp_data, held_data);
      check($sformatf("bp%0d_grant", c), grant, 0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp_release", rsp_valid, 0);
    check("bp_release_busy", busy, 0);
    tick();
    check("bp_next_grant", grant, 4'b0100);
    req = 4'b0000;
    tick();
    check("bp_next_data", rsp_data, 16'h0005);
    tick();

    // Reset during EXEC: operation is dropped.
    do_reset();
    set_slot(0, 2'b00, 16'h0001, 16'h0001);
    req = 4'b0001;
    tick();
    check("rexec_grant", grant, 4'b0001);
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    check_reset_outputs("rexec");
    reset = 1'b0;
    tick();
    check("rexec_no_rsp", rsp_valid, 0);
    check("rexec_no_busy", busy, 0);

    // Reset during RESP: response dropped, pointer restarts at index 0.
    req = 4'b0001;
    tick();
    check("rresp_grant", grant, 4'b0001);
    req = 4'b0000;
    tick();
    check("rresp_valid", rsp_valid, 1);
    reset = 1'b1;
    tick();
    check_reset_outputs("rresp");
    reset = 1'b0;
    req   = 4'b0011;
    tick();
    check("rresp_ptr", grant, 4'b0001);
    req = 4'b0000;
    tick();
    tick();
    set_slot(3, 2'b10, 16'h0003, 16'h0005);
    req = 4'b1000;
    tick();
    check("rresp_g3", grant, 4'b1000);
    req = 4'b0000;
    tick();
    check("rresp_id3", rsp_id, 3);
    check("rresp_data3", rsp_data, 16'h000F);
    tick();

    // Operand change after latch has no effect.
    set_slot(2, 2'b00, 16'h0010, 16'h0020);
    req = 4'b0100;
    tick();
    check("opchg_grant", grant, 4'b0100);
    set_slot(2, 2'b10, 16'hFFFF, 16'h0003);
    req = 4'b0000;
    check("opchg_au_a", au_data_1, 16'h0010);
    tick();
    check("opchg_data", rsp_data, 16'h0030);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
